// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: synchronous data RAM with req/ready handshake, read wait states,
// byte-lane write enables and an out-of-range error pulse.
module data_memory_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_datain,
    output logic                    d_ready,
    output logic [DATA_WIDTH-1:0]   d_dataout,
    output logic                    d_valid,
    output logic                    d_err
);
    localparam int BYTES = DATA_WIDTH / 8;
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, next_state;
    logic [3:0] cnt;
    logic [ADDR_WIDTH-1:0] addr_q, rd_addr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic accept, wr_fire, rd_fire, wr_in, rd_in;
    always_comb begin
        accept  = d_req && d_ready;
        wr_fire = accept && d_we;
        rd_addr = (state == S_IDLE) ? d_addr : addr_q;
        wr_in   = 32'(d_addr) < DEPTH;
        rd_in   = 32'(rd_addr) < DEPTH;
        // Zero-wait reads complete at the accept edge; otherwise on the last wait edge
        rd_fire = (WAIT_STATES == 0) ? (accept && !d_we) : (state == S_WAIT && cnt == 4'd1);
    end
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end
    always_comb begin
        next_state = (state == S_IDLE)
            ? ((accept && !d_we && WAIT_STATES != 0) ? S_WAIT : S_IDLE)
            : ((cnt == 4'd1) ? S_IDLE : S_WAIT);
    end
    always_comb begin
        d_ready = (state == S_IDLE);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            d_dataout <= '0;
            d_valid   <= 1'b0;
            d_err     <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
        end else begin
            d_valid <= rd_fire;
            d_err   <= (rd_fire && !rd_in) || (wr_fire && !wr_in);
            if (rd_fire) d_dataout <= rd_in ? mem[rd_addr] : '0;
            if (accept) begin
                cnt    <= 4'(WAIT_STATES);
                addr_q <= d_addr;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
    // Array has no reset: contents survive reset by design
    always_ff @(posedge clock) begin
        if (!reset && wr_fire && wr_in)
            for (int i = 0; i < BYTES; i++)
                if (d_be[i]) mem[d_addr][8*i +: 8] <= d_datain[8*i +: 8];
    end
endmodule
